mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] acc, aux, opnd, rs_raw;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state_q != IDLE);

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & rs_value[WIDTH-1];
    b_neg = sgn & rt_value[WIDTH-1];
    a_mag = a_neg ? ('0 - rs_value) : rs_value;
    b_mag = b_neg ? ('0 - rt_value) : rt_value;
  end

  // acc/aux hold {product hi, product lo} for multiply and {remainder, dividend->quotient} for divide.
  always_comb begin
    mul_sum = aux[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    shifted = {acc, aux[WIDTH-1]};
    rem_ge  = (shifted >= {1'b0, opnd});
    rem_sub = shifted[WIDTH-1:0] - opnd;
    prod    = neg_q ? ('0 - {acc, aux}) : {acc, aux};
    quo_fix = neg_q ? ('0 - aux) : aux;
    rem_fix = neg_r ? ('0 - acc) : acc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !op[2]) state_d = RUN;
      RUN:  if (cnt == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      aux      <= '0;
      opnd     <= '0;
      rs_raw   <= '0;
    end else begin
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= rs_value;
              OP_MTLO: lo <= rs_value;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= op[1] && (rt_value == '0);
                rs_raw   <= rs_value;
                acc      <= '0;
                aux      <= op[1] ? a_mag : b_mag;
                opnd     <= op[1] ? b_mag : a_mag;
                cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (rem_ge) begin
              acc <= rem_sub;
              aux <= {aux[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shifted[WIDTH-1:0];
              aux <= {aux[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            aux <= {mul_sum[0], aux[WIDTH-1:1]};
          end
        end
        FIX: begin
          cnt <= '0;
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= rs_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a queue scoreboard of expected {hi,lo}.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_value = '0;
  logic [31:0] rt_value = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int fails = 0;
  logic [63:0] scb[$];
  logic [63:0] model_hilo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_value(rs_value), .rt_value(rt_value),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int sa, sbv;
    logic [31:0] q, r;
    case (o)
      3'b000: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
      end
      3'b001: return {32'h0, a} * {32'h0, b};
      3'b011: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sbv = $signed(b);
        q = 32'(sa / sbv);
        r = 32'(sa % sbv);
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int intrude_at, input string tag);
    int cycles = 0;
    int busy_n = 0;
    int hold_bad = 0;
    logic [63:0] exp;
    scb.push_back(model(o, a, b));
    start = 1'b1; op = o; rs_value = a; rt_value = b;
    tick();
    start = 1'b0; rs_value = $urandom; rt_value = $urandom;
    while (!done && cycles < 40) begin
      if (busy) busy_n++;
      if ({hi, lo} !== model_hilo) hold_bad++;
      if (intrude_at > 0 && cycles == intrude_at - 1) begin
        start = 1'b1; op = 3'b011; rs_value = 32'd1000; rt_value = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    exp = scb.pop_front();
    check(tag, {hi, lo}, exp);
    model_hilo = exp;
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    tick();
    check("done_one_cycle", 64'(done), 64'd0);

    do_op(3'b000, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg3x7");
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    do_op(3'b011, 32'd100, 32'd0, 0, "divu_by0");
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(3'b010, 32'hFFFF_FFF9, 32'd0, 0, "div_neg_by0");
    do_op(3'b011, 32'd100, 32'd7, 0, "divu_100_7");
    do_op(3'b010, 32'd17, 32'hFFFF_FFFB, 0, "div_17_m5");
    for (int i = 0; i < 4; i++) begin
      do_op(3'($urandom_range(0, 3)), $urandom, $urandom, 0, "random");
    end

    tick();
    start = 1'b1; op = 3'b100; rs_value = 32'h1234_5678;
    tick();
    check("mthi_hilo", {hi, lo}, {32'h1234_5678, model_hilo[31:0]});
    check("mthi_busy_done", {62'h0, busy, done}, 64'h0);
    op = 3'b101; rs_value = 32'h9ABC_DEF0;
    tick();
    check("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    check("mtlo_busy_done", {62'h0, busy, done}, 64'h0);
    model_hilo = 64'h1234_5678_9ABC_DEF0;
    op = 3'b110; rs_value = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("reserved_hilo", {hi, lo}, model_hilo);
    check("reserved_busy_done", {62'h0, busy, done}, 64'h0);
    tick();
    check("reserved_done_later", {62'h0, busy, done}, 64'h0);

    do_op(3'b001, 32'h0001_0003, 32'h0000_FFFF, 5, "multu_intrude");

    start = 1'b1; op = 3'b011; rs_value = 32'd1000; rt_value = 32'd3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 64'h0);
    check("abort_busy_done", {62'h0, busy, done}, 64'h0);
    model_hilo = '0;
    tick();
    check("abort_no_done", {62'h0, busy, done}, 64'h0);
    rst_n = 1'b1;
    tick();
    check("abort_after_release", {hi, lo}, 64'h0);
    do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 0, "mult_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
